fix_msg_encoder: RTL and testbench
==================================

# fix_msg_encoder

Transmit-side FIX serializer: accepts tag/value fields in the same packed ASCII form the parser produces (32-bit tag, 256-bit value), buffers the message body, then emits a complete byte stream. The stream is `8=FIX.4.2<SOH>9=<len><SOH><body>10=<cks><SOH>`. BodyLength and CheckSum are computed in hardware. It sits between the order/response logic and the byte-wide line interface, mirroring the receive parse path.

## Interface
- BODY_DEPTH, 256: body buffer size in bytes; legal range 16..999.
- ADDR_WIDTH, 9: buffer address/length counter width; must satisfy 2^ADDR_WIDTH > BODY_DEPTH.

- clk  input  1  clock; everything synchronous to rising edge.
- rst  input  1  reset, asynchronous, active-high.
- field_valid_i  input  1  field presented.
- field_ready_o  output  1  encoder can accept a field.
- tag_i  input  32  ASCII tag; first character in [31:24].
- tag_len_i  input  3  tag characters used, 1..4.
- value_i  input  256  ASCII value; first character in [255:248].
- value_len_i  input  6  value characters used, 1..32.
- field_last_i  input  1  field is the final field of the body.
- data_o  output  8  stream byte.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts the byte.
- start_of_message_o  output  1  pulse on acceptance of the `8` byte.
- end_of_message_o  output  1  pulse on acceptance of the final SOH.
- busy_o  output  1  high from first field accepted until end_of_message_o.
- err_o  output  1  one-cycle pulse on a dropped or aborted message.

## Operation
- States: IDLE, COLLECT, WRITE, LEN, HDR, BODY, TRL.
- IDLE/COLLECT: field_ready_o=1. Handshake is field_valid_i & field_ready_o; inputs are sampled into holding registers and the state moves to WRITE.
- WRITE: writes one byte per cycle into the buffer in this order: tag chars, `=` (0x3D), value chars, SOH. That is tag_len+value_len+2 cycles, with field_ready_o=0.
  - On completion, goes to LEN if field_last was set, else to COLLECT.
- body_len counter tracks bytes written. The running checksum (8-bit, mod 256) accumulates every byte emitted.
- LEN: one cycle. Converts body_len to three BCD digits and sets the leading-zero suppression count.
- HDR: emits `8=FIX.4.2`, SOH, `9=`, the length digits without leading zeros (a value of 0 is impossible), then SOH.
- BODY: reads the buffer sequentially, body_len bytes.
- TRL: emits `10=`, the checksum as exactly 3 ASCII digits (zero-padded), then SOH. Returns to IDLE and clears body_len.
- Checksum covers every byte from `8` through the SOH preceding `10=`.
- Invalid field (tag_len 0 or >4, value_len 0 or >32):
  - The field is accepted and discarded.
  - err_o pulses.
  - The whole pending message is aborted: buffer cleared, return to IDLE.
- Overflow: if body_len+tag_len+value_len+2 > BODY_DEPTH at acceptance, the same abort and err_o pulse apply.
- No fields are accepted from LEN through TRL.

## Timing
- Reset values:
  - field_ready_o=1
  - valid_o=0
  - data_o=0x00
  - start_of_message_o=0
  - end_of_message_o=0
  - busy_o=0
  - err_o=0
  - state=IDLE
  - all counters and checksum 0
- data_o/valid_o are registered. While valid_o & !ready_i, data_o is held stable. The next byte appears the cycle after acceptance, so sustained throughput is 1 byte/cycle with ready_i held high.
- Latency: the first `8` is valid 2 cycles after the last field's WRITE completes (LEN plus register stage).
- Buffer reads are prefetched so BODY has no bubbles, including at HDR→BODY and BODY→TRL.
- Reset mid-message:
  - The stream stops immediately and valid_o drops asynchronously.
  - No partial trailer is produced.
- Abort during WRITE: err_o is asserted in the acceptance cycle +1. field_ready_o returns high the following cycle.

## Configuration
- FIX_ENC_PIPE_DELIM_EN defined: the field delimiter is `|` (0x7C) everywhere SOH appears; the checksum is computed over 0x7C. This is for lab/log readability.
- Undefined: the delimiter is SOH (0x01), per the FIX standard.

## Structure
- Shared package fix_pkg:
  - SOH/EQ/PIPE byte constants
  - the BEGIN_STRING byte sequence and its length
  - the encoder state enum
  - a bin-to-3-digit BCD function
- Sub-module fix_enc_body_buf: a simple dual-port RAM, BODY_DEPTH×8, with synchronous write and synchronous read.

## Test plan
- Single field tag "35" len 2, value "0" len 1, last → stream `8=FIX.4.2␁9=5␁35=0␁10=161␁`, 26 bytes; start/end pulses on the first/last byte.
- Same message with FIX_ENC_PIPE_DELIM_EN → `8=FIX.4.2|9=5|35=0|10=018|`.
- Fields 35=D, 49=ABC, 56=XY (last) → body length 18; `9=18`, then body bytes in order; checksum matches a software model.
- Random ready_i deasserts (50%) during the message → byte sequence identical to the ready_i=1 case; data_o never changes while valid_o & !ready_i.
- value_len_i=0 on the second field → err_o one pulse, no stream output, next valid message encodes correctly.
- Fields filling the buffer to BODY_DEPTH exactly → accepted, `9=256`; one more byte over → abort with err_o. Also assert rst mid-BODY → valid_o=0 and state IDLE.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared FIX encoder definitions: delimiter bytes, BeginString sequence,
// encoder state encoding and a small binary-to-BCD helper.
package fix_pkg;

    localparam logic [7:0] SOH  = 8'h01;
    localparam logic [7:0] EQ   = 8'h3D;
    localparam logic [7:0] PIPE = 8'h7C;

    // "8=FIX.4.2"
    localparam int BEGIN_LEN = 9;
    localparam logic [7:0] BEGIN_STRING [BEGIN_LEN] =
        '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h2E, 8'h34, 8'h2E, 8'h32};

    typedef enum logic [2:0] {
        IDLE, COLLECT, WRITE, LEN, HDR, BODY, TRL
    } enc_state_t;

    // Input must be 0..999; returns {hundreds, tens, ones}.
    function automatic logic [11:0] bin_to_bcd3(input logic [9:0] v);
        return {4'(v / 10'd100), 4'((v / 10'd10) % 10'd10), 4'(v % 10'd10)};
    endfunction

endpackage

// File: rtl/fix_enc_body_buf.sv
// Message body buffer: simple dual-port RAM, synchronous write and
// synchronous read (read data appears the cycle after the address).
module fix_enc_body_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fix_msg_encoder.sv
// FIX transmit serializer: buffers tag=value fields, then streams header,
// body and checksum trailer. FIX_ENC_PIPE_DELIM_EN selects '|' instead of SOH.
module fix_msg_encoder
    import fix_pkg::*;
#(
    parameter int BODY_DEPTH = 256,
    parameter int ADDR_WIDTH = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         field_valid_i,
    output logic         field_ready_o,
    input  logic [31:0]  tag_i,
    input  logic [2:0]   tag_len_i,
    input  logic [255:0] value_i,
    input  logic [5:0]   value_len_i,
    input  logic         field_last_i,
    output logic [7:0]   data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         start_of_message_o,
    output logic         end_of_message_o,
    output logic         busy_o,
    output logic         err_o,
    output logic [2:0]   state_o
);

`ifdef FIX_ENC_PIPE_DELIM_EN
    localparam logic [7:0] DELIM = PIPE;
`else
    localparam logic [7:0] DELIM = SOH;
`endif
    localparam int IW = $clog2(BODY_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(BODY_DEPTH);

    enc_state_t state, state_nxt;
    logic [31:0]  tag_q;
    logic [2:0]   tag_len_q;
    logic [255:0] value_q;
    logic [5:0]   value_len_q;
    logic         last_q;
    logic [5:0]   wr_cnt, idx;
    logic [ADDR_WIDTH-1:0] body_len, rd_ptr, rd_ptr_nxt;
    logic [7:0]   cks, rd_data, wr_byte, hdr_byte, trl_byte, byte_nxt;
    logic [11:0]  len_bcd, cks_bcd;
    logic [1:0]   len_nd, dpos;
    logic [ADDR_WIDTH:0] need;
    logic accept, bad_field, overflow, abort, wr_en, wr_done, hdr_last, load_en;
    logic byte_vld, byte_sof, byte_eof, sof_q, eof_q, err_q;
    logic [5:0] tag_end, val_end;

    assign field_ready_o = (state == IDLE) || (state == COLLECT);
    assign accept    = field_valid_i & field_ready_o;
    assign bad_field = (tag_len_i == 3'd0) || (tag_len_i > 3'd4) ||
                       (value_len_i == 6'd0) || (value_len_i > 6'd32);
    assign need      = {1'b0, body_len} + (ADDR_WIDTH+1)'(tag_len_i) +
                       (ADDR_WIDTH+1)'(value_len_i) + (ADDR_WIDTH+1)'(2);
    assign overflow  = need > DEPTH_W;
    assign load_en   = !valid_o || ready_i;

    assign start_of_message_o = valid_o & ready_i & sof_q;
    assign end_of_message_o   = valid_o & ready_i & eof_q;
    assign busy_o  = (state != IDLE);
    assign err_o   = err_q;
    assign state_o = state;

    assign tag_end  = {3'b0, tag_len_q};
    assign val_end  = tag_end + value_len_q + 6'd1;
    assign wr_done  = (wr_cnt == val_end);
    assign hdr_last = (idx == 6'd12 + {4'b0, len_nd});
    // Length digits start at idx 12; 12 is a multiple of 4 so idx[1:0] aligns.
    assign dpos     = idx[1:0] + (2'd3 - len_nd);
    assign cks_bcd  = bin_to_bcd3({2'b0, cks});

    always_comb begin
        wr_byte = DELIM;
        if (wr_cnt < tag_end)       wr_byte = tag_q[31:24];
        else if (wr_cnt == tag_end) wr_byte = EQ;
        else if (wr_cnt < val_end)  wr_byte = value_q[255:248];
    end

    always_comb begin
        hdr_byte = DELIM;
        if (idx < 6'(BEGIN_LEN))   hdr_byte = BEGIN_STRING[idx[3:0]];
        else if (idx == 6'd10)     hdr_byte = 8'h39;
        else if (idx == 6'd11)     hdr_byte = EQ;
        else if (idx >= 6'd12 && !hdr_last) begin
            case (dpos)
                2'd0:    hdr_byte = {4'h3, len_bcd[11:8]};
                2'd1:    hdr_byte = {4'h3, len_bcd[7:4]};
                default: hdr_byte = {4'h3, len_bcd[3:0]};
            endcase
        end
    end

    always_comb begin
        case (idx)
            6'd0:    trl_byte = 8'h31;
            6'd1:    trl_byte = 8'h30;
            6'd2:    trl_byte = EQ;
            6'd3:    trl_byte = {4'h3, cks_bcd[11:8]};
            6'd4:    trl_byte = {4'h3, cks_bcd[7:4]};
            6'd5:    trl_byte = {4'h3, cks_bcd[3:0]};
            default: trl_byte = DELIM;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        byte_nxt   = 8'h00;
        byte_vld   = 1'b0;
        byte_sof   = 1'b0;
        byte_eof   = 1'b0;
        wr_en      = 1'b0;
        abort      = 1'b0;
        rd_ptr_nxt = '0;
        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (bad_field || overflow) begin
                        abort     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                if (wr_done) state_nxt = last_q ? LEN : COLLECT;
            end
            LEN: state_nxt = HDR;
            HDR: begin
                rd_ptr_nxt = rd_ptr;
                if (load_en) begin
                    byte_vld = 1'b1;
                    byte_sof = (idx == 6'd0);
                    byte_nxt = hdr_byte;
                    if (hdr_last) state_nxt = BODY;
                end
            end
            BODY: begin
                rd_ptr_nxt = rd_ptr;
                if (load_en) begin
                    byte_vld   = 1'b1;
                    byte_nxt   = rd_data;
                    rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
                    if (rd_ptr == body_len - ADDR_WIDTH'(1)) state_nxt = TRL;
                end
            end
            TRL: begin
                rd_ptr_nxt = rd_ptr;
                // idx 7: final delimiter loaded, wait until it is taken.
                if (idx == 6'd7) begin
                    if (load_en) state_nxt = IDLE;
                end else if (load_en) begin
                    byte_vld = 1'b1;
                    byte_eof = (idx == 6'd6);
                    byte_nxt = trl_byte;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tag_q <= '0; tag_len_q <= '0; value_q <= '0; value_len_q <= '0;
            last_q <= 1'b0; wr_cnt <= '0; idx <= '0;
            body_len <= '0; rd_ptr <= '0; cks <= '0;
            len_bcd <= '0; len_nd <= 2'd1;
            data_o <= 8'h00; valid_o <= 1'b0;
            sof_q <= 1'b0; eof_q <= 1'b0; err_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_ptr_nxt;
            err_q  <= abort;
            if (accept && !abort) begin
                tag_q <= tag_i; tag_len_q <= tag_len_i;
                value_q <= value_i; value_len_q <= value_len_i;
                last_q <= field_last_i; wr_cnt <= '0;
            end
            if (abort) body_len <= '0;
            if (wr_en) begin
                body_len <= body_len + ADDR_WIDTH'(1);
                wr_cnt   <= wr_cnt + 6'd1;
                if (wr_cnt < tag_end) tag_q <= tag_q << 8;
                else if (wr_cnt > tag_end) value_q <= value_q << 8;
            end
            if (state == LEN) begin
                len_bcd <= bin_to_bcd3(10'(body_len));
                if (bin_to_bcd3(10'(body_len)) >= 12'h100)     len_nd <= 2'd3;
                else if (bin_to_bcd3(10'(body_len)) >= 12'h010) len_nd <= 2'd2;
                else                                            len_nd <= 2'd1;
            end
            if (byte_vld && (state == HDR || state == BODY)) cks <= cks + byte_nxt;
            if (byte_vld && state == HDR) idx <= hdr_last ? 6'd0 : idx + 6'd1;
            if (byte_vld && state == TRL) idx <= idx + 6'd1;
            if (state == TRL && state_nxt == IDLE) begin
                body_len <= '0; cks <= '0; idx <= '0;
            end
            if (load_en) begin
                valid_o <= byte_vld;
                if (byte_vld) begin
                    data_o <= byte_nxt;
                    sof_q  <= byte_sof;
                    eof_q  <= byte_eof;
                end
            end
        end
    end

    fix_enc_body_buf #(.DEPTH(BODY_DEPTH), .AW(IW)) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (body_len[IW-1:0]),
        .wdata (wr_byte),
        .raddr (rd_ptr_nxt[IW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fix_msg_encoder.sv
// Bench for fix_msg_encoder: a reference model builds each expected byte
// stream from the field list; tasks drive fields and collect the output.
module tb_fix_msg_encoder;
    import fix_pkg::*;

`ifdef FIX_ENC_PIPE_DELIM_EN
    localparam logic [7:0] DLM = 8'h7C;
    localparam string LIT_SINGLE = "8=FIX.4.2_9=5_35=0_10=018_";
`else
    localparam logic [7:0] DLM = 8'h01;
    localparam string LIT_SINGLE = "8=FIX.4.2_9=5_35=0_10=161_";
`endif

    logic clk = 1'b0;
    logic rst;
    logic field_valid_i, field_ready_o, field_last_i;
    logic [31:0] tag_i;
    logic [2:0] tag_len_i;
    logic [255:0] value_i;
    logic [5:0] value_len_i;
    logic [7:0] data_o;
    logic valid_o, ready_i, start_of_message_o, end_of_message_o, busy_o, err_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    fix_msg_encoder #(.BODY_DEPTH(256), .ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst),
        .field_valid_i(field_valid_i), .field_ready_o(field_ready_o),
        .tag_i(tag_i), .tag_len_i(tag_len_i),
        .value_i(value_i), .value_len_i(value_len_i),
        .field_last_i(field_last_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .start_of_message_o(start_of_message_o),
        .end_of_message_o(end_of_message_o),
        .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
    );

    typedef struct {
        logic [31:0]  tag;
        int           tl;
        logic [255:0] val;
        int           vl;
    } fld_t;

    int checks = 0;
    int errors = 0;
    fld_t msg[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int sof_cnt, eof_cnt, err_cnt, sof_pos, eof_pos;

    function automatic fld_t make_field(input int tl, input int vl);
        fld_t f;
        f.tag = '0;
        f.val = '0;
        f.tl = tl;
        f.vl = vl;
        for (int k = 0; k < tl; k++) f.tag[31-8*k -: 8] = 8'($urandom_range(48, 57));
        for (int k = 0; k < vl; k++) f.val[255-8*k -: 8] = 8'($urandom_range(33, 126));
        return f;
    endfunction

    function automatic fld_t str_field(input string t, input string v);
        fld_t f;
        f.tag = '0;
        f.val = '0;
        f.tl = t.len();
        f.vl = v.len();
        for (int k = 0; k < f.tl; k++) f.tag[31-8*k -: 8] = t[k];
        for (int k = 0; k < f.vl; k++) f.val[255-8*k -: 8] = v[k];
        return f;
    endfunction

    // Reference: header + body + "10=ccc" + delimiter, checksum = byte sum mod 256.
    function automatic void build_exp();
        logic [7:0] body[$];
        string s;
        int sum;
        body = {};
        exp_q = {};
        foreach (msg[i]) begin
            for (int k = 0; k < msg[i].tl; k++) body.push_back(msg[i].tag[31-8*k -: 8]);
            body.push_back(8'h3D);
            for (int k = 0; k < msg[i].vl; k++) body.push_back(msg[i].val[255-8*k -: 8]);
            body.push_back(DLM);
        end
        s = "8=FIX.4.2";
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(DLM);
        s = $sformatf("9=%0d", body.size());
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(DLM);
        foreach (body[i]) exp_q.push_back(body[i]);
        sum = 0;
        foreach (exp_q[i]) sum += int'(exp_q[i]);
        s = $sformatf("10=%03d", sum % 256);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(DLM);
    endfunction

    task automatic drive_field(input logic [31:0] t, input logic [2:0] tl,
                               input logic [255:0] v, input logic [5:0] vl,
                               input logic last);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        tag_i = t; tag_len_i = tl; value_i = v; value_len_i = vl;
        field_last_i = last; field_valid_i = 1'b1;
        @(negedge clk);
        while (!field_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (field_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL field_accept: field_ready_o=%b required 1 within 500 cycles", field_ready_o);
        end
        @(posedge clk);
        #1;
        field_valid_i = 1'b0;
    endtask

    task automatic send_msg();
        foreach (msg[i])
            drive_field(msg[i].tag, 3'(msg[i].tl), msg[i].val, 6'(msg[i].vl),
                        (i == msg.size() - 1));
    endtask

    // Collect output until end_of_message_o or the cycle budget runs out.
    task automatic collect(input bit rand_ready, input int max_cycles);
        logic prev_stall;
        logic [7:0] prev_data;
        got_q = {};
        sof_cnt = 0; eof_cnt = 0; err_cnt = 0; sof_pos = -1; eof_pos = -1;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        for (int c = 0; c < max_cycles && eof_cnt == 0; c++) begin
            @(negedge clk);
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                checks++;
                if (data_o !== prev_data || valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: data_o=%h valid_o=%b required data_o=%h valid_o=1",
                             data_o, valid_o, prev_data);
                end
            end
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (start_of_message_o === 1'b1) begin sof_cnt++; sof_pos = got_q.size(); end
            if (end_of_message_o === 1'b1) begin eof_cnt++; eof_pos = got_q.size(); end
            if (err_o === 1'b1) err_cnt++;
            prev_stall = valid_o && !ready_i;
            prev_data = data_o;
        end
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = -1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_bytes: byte %0d is %h, required %h", name, bad, got_q[bad], exp_q[bad]);
        end
        checks++;
        if (sof_cnt != 1 || sof_pos != 1) begin
            errors++;
            $display("FAIL %s_sof: pulses=%0d at byte %0d, required 1 at byte 1", name, sof_cnt, sof_pos);
        end
        checks++;
        if (eof_cnt != 1 || eof_pos != exp_q.size()) begin
            errors++;
            $display("FAIL %s_eof: pulses=%0d at byte %0d, required 1 at byte %0d",
                     name, eof_cnt, eof_pos, exp_q.size());
        end
    endtask

    task automatic run_msg(input string name, input bit rand_ready);
        build_exp();
        send_msg();
        collect(rand_ready, 3000);
        check_stream(name);
        msg = {};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        field_valid_i = 1'b0; tag_i = '0; tag_len_i = '0; value_i = '0;
        value_len_i = '0; field_last_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({field_ready_o, valid_o, data_o, start_of_message_o, end_of_message_o, busy_o, err_o}
            !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h sof=%b eof=%b busy=%b err=%b required 1 0 00 0 0 0 0",
                     field_ready_o, valid_o, data_o, start_of_message_o, end_of_message_o, busy_o, err_o);
        end
        checks++;
        if (state_o !== 3'(IDLE)) begin
            errors++;
            $display("FAIL reset_state: state_o=%0d required %0d", state_o, 3'(IDLE));
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_field();
        logic [7:0] b;
        int bad;
        msg.push_back(str_field("35", "0"));
        run_msg("single", 1'b0);
        bad = -1;
        for (int i = 0; i < LIT_SINGLE.len(); i++) begin
            b = (LIT_SINGLE[i] == 8'h5F) ? DLM : LIT_SINGLE[i];
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== b)) bad = i;
        end
        checks++;
        if (bad >= 0 || got_q.size() != 26) begin
            errors++;
            $display("FAIL single_literal: %0d bytes, first difference at %0d, required %s (26 bytes)",
                     got_q.size(), bad, LIT_SINGLE);
        end
    endtask

    task automatic test_multi_field();
        msg.push_back(str_field("35", "D"));
        msg.push_back(str_field("49", "ABC"));
        msg.push_back(str_field("56", "XY"));
        run_msg("multi", 1'b0);
        checks++;
        if (got_q.size() < 14 || got_q[10] !== 8'h39 || got_q[12] !== 8'h31 || got_q[13] !== 8'h38) begin
            errors++;
            $display("FAIL multi_bodylen: got %0d bytes, BodyLength field differs from 9=18", got_q.size());
        end
    endtask

    task automatic test_random_ready();
        for (int m = 0; m < 3; m++) begin
            int nf;
            nf = $urandom_range(1, 4);
            for (int i = 0; i < nf; i++) msg.push_back(make_field($urandom_range(1, 4), $urandom_range(1, 32)));
            run_msg($sformatf("rand_ready%0d", m), 1'b1);
        end
    endtask

    task automatic test_invalid_field();
        fld_t f;
        f = str_field("35", "D");
        drive_field(f.tag, 3'(f.tl), f.val, 6'(f.vl), 1'b0);
        f = str_field("49", "X");
        drive_field(f.tag, 3'(f.tl), f.val, 6'd0, 1'b1);
        collect(1'b0, 60);
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL invalid_err: err_o pulses=%0d required 1", err_cnt);
        end
        checks++;
        if (got_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_quiet: %0d bytes, busy_o=%b required 0 bytes, busy_o=0", got_q.size(), busy_o);
        end
        msg.push_back(str_field("35", "A"));
        msg.push_back(str_field("49", "Z"));
        run_msg("after_invalid", 1'b0);
    endtask

    task automatic test_fill_buffer();
        for (int i = 0; i < 7; i++) msg.push_back(make_field(4, 30));
        msg.push_back(make_field(1, 1));
        run_msg("fill", 1'b0);
        checks++;
        if (got_q.size() != 279) begin
            errors++;
            $display("FAIL fill_total: got %0d bytes, required 279 (9=256)", got_q.size());
        end
        for (int i = 0; i < 7; i++) msg.push_back(make_field(4, 30));
        msg.push_back(make_field(2, 1));
        send_msg();
        msg = {};
        collect(1'b0, 80);
        checks++;
        if (err_cnt != 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL overflow: err pulses=%0d bytes=%0d required 1 pulse, 0 bytes", err_cnt, got_q.size());
        end
    endtask

    task automatic test_reset_mid_body();
        int got;
        got = 0;
        for (int i = 0; i < 7; i++) msg.push_back(make_field(4, 30));
        send_msg();
        msg = {};
        ready_i = 1'b1;
        for (int c = 0; c < 2000 && got < 30; c++) begin
            @(negedge clk);
            #1;
            if (valid_o && ready_i) got++;
        end
        checks++;
        if (got < 30) begin
            errors++;
            $display("FAIL midbody_reach: got %0d bytes, required 30", got);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || state_o !== 3'(IDLE) || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midbody_reset: valid_o=%b state_o=%0d busy_o=%b required 0 %0d 0",
                     valid_o, state_o, busy_o, 3'(IDLE));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 3; m++) begin
            int nf;
            nf = $urandom_range(1, 4);
            for (int i = 0; i < nf; i++) msg.push_back(make_field($urandom_range(1, 4), $urandom_range(1, 32)));
            run_msg($sformatf("b2b%0d", m), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_field();
        test_multi_field();
        test_random_ready();
        test_invalid_field();
        test_fill_buffer();
        test_reset_mid_body();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
